apb_master_ctrl: RTL and testbench

- APB initiator. Converts a simple valid/ready command interface into APB3/APB4 read and write transfers toward peripherals such as the 64-bit timer.
- Sits between an internal controller (CPU stub, DMA or test sequencer) and the peripheral's tim_* APB slave port.
- Provides wait-state handling, a pslverr return path, a watchdog timeout, and local rejection of misaligned addresses.

---
 rtl/apb_master_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_apb_master_ctrl.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/apb_master_ctrl.sv
// APB initiator: turns a valid/ready command into one APB SETUP/ACCESS transfer
// and returns a single-cycle response with error, timeout and misalignment reporting.
module apb_master_ctrl #(
    parameter int ADDR_W  = 12,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 16
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_W-1:0]     cmd_addr,
    input  logic [DATA_W-1:0]     cmd_wdata,
    input  logic [DATA_W/8-1:0]   cmd_strb,
    output logic                  rsp_valid,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  rsp_err,
    output logic                  rsp_timeout,
    output logic                  apb_psel,
    output logic                  apb_penable,
    output logic                  apb_pwrite,
    output logic [ADDR_W-1:0]     apb_paddr,
    output logic [DATA_W-1:0]     apb_pwdata,
    output logic [DATA_W/8-1:0]   apb_pstrb,
    input  logic                  apb_pready,
    input  logic [DATA_W-1:0]     apb_prdata,
    input  logic                  apb_pslverr
);

    localparam int STRB_W = DATA_W / 8;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETUP  = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] TO_LIM  = CNT_W'(TIMEOUT);

    // Wait counter saturates so a disabled watchdog never wraps back through the limit.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] val);
        if (val == CNT_MAX) begin
            return val;
        end else begin
            return val + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    endfunction

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              psel_q, psel_d;
    logic              penable_q, penable_d;
    logic              pwrite_q, pwrite_d;
    logic [ADDR_W-1:0] paddr_q, paddr_d;
    logic [DATA_W-1:0] pwdata_q, pwdata_d;
    logic [STRB_W-1:0] pstrb_q, pstrb_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;
    logic              rsp_timeout_q, rsp_timeout_d;
    logic              timeout_hit_s;

    // The abort fires on the edge that would bring the count of unready ACCESS cycles to TIMEOUT.
    assign timeout_hit_s = (TIMEOUT != 0) && !apb_pready && (sat_inc(cnt_q) >= TO_LIM);

    // Next-state and next-output logic for the IDLE/SETUP/ACCESS sequencer.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        psel_d        = psel_q;
        penable_d     = penable_q;
        pwrite_d      = pwrite_q;
        paddr_d       = paddr_q;
        pwdata_d      = pwdata_q;
        pstrb_d       = pstrb_q;
        rsp_valid_d   = 1'b0;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_err_d     = rsp_err_q;
        rsp_timeout_d = rsp_timeout_q;

        case (state_q)
            ST_IDLE: begin
                cnt_d     = {CNT_W{1'b0}};
                psel_d    = 1'b0;
                penable_d = 1'b0;
                if (cmd_valid) begin
                    if (cmd_addr[1:0] != 2'b00) begin
                        rsp_valid_d   = 1'b1;
                        rsp_err_d     = 1'b1;
                        rsp_timeout_d = 1'b0;
                        rsp_rdata_d   = {DATA_W{1'b0}};
                    end else begin
                        state_d  = ST_SETUP;
                        psel_d   = 1'b1;
                        pwrite_d = cmd_write;
                        paddr_d  = cmd_addr;
                        pwdata_d = cmd_write ? cmd_wdata : {DATA_W{1'b0}};
                        pstrb_d  = cmd_write ? cmd_strb : {STRB_W{1'b0}};
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SETUP: begin
                state_d   = ST_ACCESS;
                penable_d = 1'b1;
            end
            ST_ACCESS: begin
                if (apb_pready) begin
                    state_d       = ST_IDLE;
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_err_d     = apb_pslverr;
                    rsp_timeout_d = 1'b0;
                    rsp_rdata_d   = (!pwrite_q && !apb_pslverr) ? apb_prdata : {DATA_W{1'b0}};
                end else if (timeout_hit_s) begin
                    state_d       = ST_IDLE;
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_err_d     = 1'b1;
                    rsp_timeout_d = 1'b1;
                    rsp_rdata_d   = {DATA_W{1'b0}};
                end else begin
                    cnt_d = sat_inc(cnt_q);
                end
            end
            default: begin
                state_d   = ST_IDLE;
                psel_d    = 1'b0;
                penable_d = 1'b0;
            end
        endcase
    end

    // State and registered outputs; reset drops the bus immediately and discards any transfer.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q       <= ST_IDLE;
            cnt_q         <= {CNT_W{1'b0}};
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            pwrite_q      <= 1'b0;
            paddr_q       <= {ADDR_W{1'b0}};
            pwdata_q      <= {DATA_W{1'b0}};
            pstrb_q       <= {STRB_W{1'b0}};
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= {DATA_W{1'b0}};
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            psel_q        <= psel_d;
            penable_q     <= penable_d;
            pwrite_q      <= pwrite_d;
            paddr_q       <= paddr_d;
            pwdata_q      <= pwdata_d;
            pstrb_q       <= pstrb_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_err_q     <= rsp_err_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    assign cmd_ready   = (state_q == ST_IDLE);
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_err     = rsp_err_q;
    assign rsp_timeout = rsp_timeout_q;
    assign apb_psel    = psel_q;
    assign apb_penable = penable_q;
    assign apb_pwrite  = pwrite_q;
    assign apb_paddr   = paddr_q;
    assign apb_pwdata  = pwdata_q;
    assign apb_pstrb   = pstrb_q;

endmodule

// File: tb/tb_apb_master_ctrl.sv
// Randomized self-checking bench for apb_master_ctrl with a cycle-level transaction model
// and a scripted APB slave.
module tb_apb_master_ctrl;

    localparam int AW = 12;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int TO = 8;

    logic          sys_clk = 1'b0;
    logic          sys_rst_n;
    logic          cmd_valid, cmd_ready, cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic [SW-1:0] cmd_strb;
    logic          rsp_valid, rsp_err, rsp_timeout;
    logic [DW-1:0] rsp_rdata;
    logic          apb_psel, apb_penable, apb_pwrite;
    logic [AW-1:0] apb_paddr;
    logic [DW-1:0] apb_pwdata, apb_prdata;
    logic [SW-1:0] apb_pstrb;
    logic          apb_pready, apb_pslverr;

    int checks = 0;
    int errors = 0;

    logic          last_err = 1'b0;
    logic          last_to  = 1'b0;
    logic [DW-1:0] last_rd  = '0;

    apb_master_ctrl #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO), .CNT_W(16)) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .rsp_timeout(rsp_timeout),
        .apb_psel(apb_psel), .apb_penable(apb_penable), .apb_pwrite(apb_pwrite),
        .apb_paddr(apb_paddr), .apb_pwdata(apb_pwdata), .apb_pstrb(apb_pstrb),
        .apb_pready(apb_pready), .apb_prdata(apb_prdata), .apb_pslverr(apb_pslverr)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One command from a negedge until the negedge of its response cycle. The slave
    // raises pready in ACCESS cycle number waits (0-based) unless to is set.
    task automatic run_txn(input bit wr, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                           input logic [SW-1:0] st, input int waits, input bit to,
                           input bit serr, input logic [DW-1:0] rd, input bit hold);
        bit            mis;
        int            n_acc;
        int            last;
        logic [DW-1:0] exp_wd;
        logic [SW-1:0] exp_st;
        logic [DW-1:0] exp_rd;
        bit            exp_err;
        mis     = (addr[1:0] != 2'b00);
        n_acc   = to ? TO : waits + 1;
        last    = mis ? 1 : 2 + n_acc;
        exp_wd  = wr ? wd : '0;
        exp_st  = wr ? st : '0;
        exp_rd  = (mis || to || wr || serr) ? '0 : rd;
        exp_err = mis || to || serr;

        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wd; cmd_strb = st;
        chk("cmd_ready_accept", cmd_ready, 1);
        @(posedge sys_clk); #1;
        for (int c = 1; c <= last; c++) begin
            if (hold) begin
                cmd_valid = 1'b1;
                cmd_write = 1'($urandom);
                cmd_addr  = AW'($urandom);
                cmd_wdata = $urandom;
            end else begin
                cmd_valid = 1'b0;
            end
            apb_pready  = !mis && !to && (c == 2 + waits);
            apb_prdata  = apb_pready ? rd : $urandom;
            apb_pslverr = apb_pready ? serr : 1'($urandom);
            @(negedge sys_clk);
            if (c == last) begin
                chk("rsp_valid", rsp_valid, 1);
                chk("rsp_err", rsp_err, exp_err);
                chk("rsp_timeout", rsp_timeout, to && !mis);
                chk("rsp_rdata", rsp_rdata, exp_rd);
                chk("rsp_psel", apb_psel, 0);
                chk("rsp_penable", apb_penable, 0);
                chk("rsp_cmd_ready", cmd_ready, 1);
            end else begin
                chk(c == 1 ? "setup_penable" : "access_penable", apb_penable, c != 1);
                chk("busy_psel", apb_psel, 1);
                chk("busy_paddr", apb_paddr, addr);
                chk("busy_pwrite", apb_pwrite, wr);
                chk("busy_pwdata", apb_pwdata, exp_wd);
                chk("busy_pstrb", apb_pstrb, exp_st);
                chk("busy_rsp_valid", rsp_valid, 0);
                chk("busy_cmd_ready", cmd_ready, 0);
            end
            if (c < last) begin
                @(posedge sys_clk); #1;
            end
        end
        apb_pready = 1'b0;
        last_err = exp_err;
        last_to  = to && !mis;
        last_rd  = exp_rd;
    endtask

    // Idle cycles from a negedge: no response pulse and the previous response held.
    task automatic idle(input int k);
        cmd_valid = 1'b0;
        for (int i = 0; i < k; i++) begin
            @(negedge sys_clk);
            chk("idle_rsp_valid", rsp_valid, 0);
            chk("idle_psel", apb_psel, 0);
            chk("idle_cmd_ready", cmd_ready, 1);
            chk("hold_rsp_err", rsp_err, last_err);
            chk("hold_rsp_timeout", rsp_timeout, last_to);
            chk("hold_rsp_rdata", rsp_rdata, last_rd);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got running expected done");
        $fatal(1);
    end

    initial begin
        bit            wr, to, serr, mis;
        logic [AW-1:0] addr;
        sys_rst_n = 1'b0;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_strb = '0;
        apb_pready = 1'b0; apb_prdata = '0; apb_pslverr = 1'b0;
        #12;
        chk("reset_cmd_ready", cmd_ready, 1);
        chk("reset_psel", apb_psel, 0);
        chk("reset_penable", apb_penable, 0);
        chk("reset_rsp_valid", rsp_valid, 0);
        chk("reset_paddr", apb_paddr, 0);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        idle(2);

        run_txn(1'b1, 12'h000, 32'h0000_0003, 4'hF, 0, 1'b0, 1'b0, 32'h0, 1'b0);
        idle(1);
        run_txn(1'b0, 12'h004, 32'hFFFF_FFFF, 4'hF, 3, 1'b0, 1'b0, 32'hDEAD_BEEF, 1'b0);
        idle(1);
        run_txn(1'b0, 12'h008, 32'h0, 4'h0, 0, 1'b0, 1'b1, 32'h0000_1234, 1'b0);
        idle(1);
        run_txn(1'b0, 12'h00C, 32'h0, 4'h0, 0, 1'b1, 1'b0, 32'h0, 1'b0);
        idle(1);
        run_txn(1'b1, 12'h020, 32'hA5A5_5A5A, 4'h3, 1, 1'b0, 1'b0, 32'h0, 1'b0);
        idle(1);
        run_txn(1'b1, 12'h006, 32'h1111_2222, 4'hF, 0, 1'b0, 1'b0, 32'h0, 1'b0);
        idle(1);
        run_txn(1'b1, 12'h000, 32'hCAFE_0001, 4'hF, 0, 1'b0, 1'b0, 32'h0, 1'b1);
        run_txn(1'b1, 12'h010, 32'hCAFE_0002, 4'hC, 0, 1'b0, 1'b0, 32'h0, 1'b0);
        idle(1);

        for (int i = 0; i < 40; i++) begin
            wr   = 1'($urandom);
            mis  = ($urandom_range(0, 3) == 0);
            to   = ($urandom_range(0, 7) == 0);
            serr = ($urandom_range(0, 3) == 0);
            addr = AW'($urandom);
            addr[1:0] = mis ? 2'($urandom_range(1, 3)) : 2'b00;
            run_txn(wr, addr, $urandom, SW'($urandom), $urandom_range(0, 5), to, serr,
                    $urandom, 1'($urandom));
        end
        idle(2);

        // Reset during the ACCESS phase of a read.
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 12'h040; cmd_strb = '0;
        @(posedge sys_clk); #1;
        cmd_valid = 1'b0;
        @(posedge sys_clk); #1;
        @(negedge sys_clk);
        chk("pre_reset_penable", apb_penable, 1);
        #2;
        sys_rst_n = 1'b0;
        #1;
        chk("async_psel", apb_psel, 0);
        chk("async_penable", apb_penable, 0);
        chk("async_rsp_valid", rsp_valid, 0);
        chk("async_cmd_ready", cmd_ready, 1);
        chk("async_rsp_err", rsp_err, 0);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        last_err = 1'b0; last_to = 1'b0; last_rd = '0;
        idle(3);
        run_txn(1'b0, 12'h044, 32'h0, 4'h0, 1, 1'b0, 1'b0, 32'h0BAD_F00D, 1'b0);
        idle(1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
